// File: rtl/core_seq_if.sv
// -----------------------------------------------------------------------------
// core_seq_if -- memory request/acknowledge bus between core_seq and memory.
//
// Signals:
//   mem_req    core -> mem  request, held until accepted
//   mem_ack    mem  -> core request accepted/completed this cycle
//   mem_addr   core -> mem  address (stable while mem_req=1)
//   mem_wdata  core -> mem  write data (stable while mem_req=1)
//   mem_we     core -> mem  1 = write, 0 = read (stable while mem_req=1)
//   mem_rdata  mem  -> core read data, valid in the cycle mem_ack=1
//
// Modports: master (core side), slave (memory side).
// -----------------------------------------------------------------------------
interface core_seq_if #(
    parameter int DATA_W = 16
) ();
    logic              mem_req;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_addr, mem_wdata, mem_we,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr, mem_wdata, mem_we,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/core_seq.sv
// -----------------------------------------------------------------------------
// core_seq -- fetch / execute / memory / writeback sequencer around an
// external combinational instruction decoder. Owns the PC and register file
// and talks to memory over core_seq_if with arbitrary wait states.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   mem                 core_seq_if.master memory bus
//   dec_instruction     latched instruction to the decoder
//   dec_pc              current PC to the decoder
//   dec_regs            register file, reg 0 in the MSB slice
//   dec_res .. dec_halt decoder results (sampled on the EXEC edge)
//   run                 restart pulse, honoured only while halted
//   halt_out            core halted
//   retired_count       (CORE_SEQ_RETIRE_COUNT_EN only) retired instructions
//
// Optional feature macro: CORE_SEQ_RETIRE_COUNT_EN
// -----------------------------------------------------------------------------
module core_seq #(
    parameter int                DATA_W   = 16,
    parameter int                NREGS    = 6,
    parameter int                TGT_W    = 3,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    core_seq_if.master              mem,
    output logic [DATA_W-1:0]       dec_instruction,
    output logic [DATA_W-1:0]       dec_pc,
    output logic [NREGS*DATA_W-1:0] dec_regs,
    input  logic [DATA_W-1:0]       dec_res,
    input  logic [TGT_W-1:0]        dec_res_target,
    input  logic                    dec_res_from_ram,
    input  logic                    dec_ram_access,
    input  logic                    dec_ram_op,
    input  logic [DATA_W-1:0]       dec_ram_addr,
    input  logic [DATA_W-1:0]       dec_ram_wdata,
    input  logic [3:0]              dec_ram_mode,
    input  logic                    dec_halt,
    input  logic                    run,
    output logic                    halt_out
`ifdef CORE_SEQ_RETIRE_COUNT_EN
    ,
    output logic [31:0]             retired_count
`endif
);
    localparam int HALF = DATA_W / 2;

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_EXEC  = 3'd1;
    localparam logic [2:0] S_MEM   = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    logic [2:0]        r_state;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] r_regs [NREGS];
    logic              r_halt;

    // Memory bus outputs are registered so they stay glitch-free and stable
    // for the whole request, and a reset can drop mem_req asynchronously.
    logic              r_mem_req;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_we;

    // Decoder results captured on the EXEC edge.
    logic [DATA_W-1:0] r_ex_res;
    logic [TGT_W-1:0]  r_ex_tgt;
    logic              r_ex_from_ram;
    logic [3:0]        r_ex_mode;
    logic [DATA_W-1:0] r_rdata;

    logic [DATA_W-1:0] w_sw;
    logic [DATA_W-1:0] w_res;
    logic              w_tgt_reg;
    logic [DATA_W-1:0] w_next_pc;

    // Writeback result and next PC.
    // NOTE: every always_comb output gets a default first, otherwise a path
    // that skips an assignment infers a latch.
    always_comb begin
        w_sw  = r_ex_mode[1] ? {r_rdata[HALF-1:0], r_rdata[DATA_W-1:HALF]} : r_rdata;
        w_res = r_ex_res;
        if (r_ex_from_ram) begin
            if (r_ex_mode[0]) begin
                w_res = r_ex_mode[1] ? (r_ex_res - r_rdata) : (r_ex_res + r_rdata);
            end else begin
                if (r_ex_mode[2]) w_res[DATA_W-1:HALF] = w_sw[DATA_W-1:HALF];
                if (r_ex_mode[3]) w_res[HALF-1:0]      = w_sw[HALF-1:0];
            end
        end
        w_tgt_reg = (int'(r_ex_tgt) >= 2) && (int'(r_ex_tgt) <= NREGS + 1);
        w_next_pc = (int'(r_ex_tgt) == 1) ? w_res : (r_pc + DATA_W'(1));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_halt        <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_we      <= 1'b0;
            r_ex_res      <= '0;
            r_ex_tgt      <= '0;
            r_ex_from_ram <= 1'b0;
            r_ex_mode     <= '0;
            r_rdata       <= '0;
            // NOTE: the register file is architecturally visible and must read
            // zero after reset, so it is built from resettable flops rather
            // than an inferred RAM.
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    // After reset nothing is requested yet; raise the fetch.
                    if (!r_mem_req) begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_pc;
                        r_mem_we   <= 1'b0;
                    end else if (mem.mem_ack) begin
                        r_instr   <= mem.mem_rdata;
                        r_mem_req <= 1'b0;
                        r_state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_ex_res      <= dec_res;
                    r_ex_tgt      <= dec_res_target;
                    r_ex_from_ram <= dec_res_from_ram;
                    r_ex_mode     <= dec_ram_mode;
                    r_rdata       <= '0;
                    if (dec_halt) begin
                        r_halt  <= 1'b1;
                        r_state <= S_HALT;
                    end else if (dec_ram_access) begin
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= dec_ram_addr;
                        r_mem_wdata <= dec_ram_wdata;
                        r_mem_we    <= dec_ram_op;
                        r_state     <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem.mem_ack) begin
                        if (!r_mem_we) r_rdata <= mem.mem_rdata;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= S_WB;
                    end
                end
                S_WB: begin
                    for (int i = 0; i < NREGS; i++) begin
                        if (w_tgt_reg && (int'(r_ex_tgt) == i + 2)) r_regs[i] <= w_res;
                    end
                    // Issue the next fetch directly so FETCH can complete on
                    // its first cycle with a zero-wait memory.
                    r_pc       <= w_next_pc;
                    r_mem_req  <= 1'b1;
                    r_mem_addr <= w_next_pc;
                    r_mem_we   <= 1'b0;
                    r_state    <= S_FETCH;
                end
                S_HALT: begin
                    if (run) begin
                        r_halt     <= 1'b0;
                        r_pc       <= r_pc + DATA_W'(1);
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_pc + DATA_W'(1);
                        r_mem_we   <= 1'b0;
                        r_state    <= S_FETCH;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

`ifdef CORE_SEQ_RETIRE_COUNT_EN
    logic [31:0] r_retired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 r_retired <= '0;
        else if (r_state == S_WB) r_retired <= r_retired + 32'd1;
    end

    assign retired_count = r_retired;
`endif

    generate
        for (genvar g = 0; g < NREGS; g++) begin : g_regs
            assign dec_regs[(NREGS-g)*DATA_W-1 -: DATA_W] = r_regs[g];
        end
    endgenerate

    assign mem.mem_req   = r_mem_req;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
    assign mem.mem_we    = r_mem_we;
    assign dec_instruction = r_instr;
    assign dec_pc          = r_pc;
    assign halt_out        = r_halt;
endmodule

// File: tb/tb_core_seq.sv
// -----------------------------------------------------------------------------
// tb_core_seq -- self-checking bench for core_seq. The bench plays both the
// memory (with programmable wait states) and the decoder, and keeps an
// architectural model (PC + register array) updated per retired instruction.
// NREGS=5 so that target 7 is out of range for a 3-bit target field.
// -----------------------------------------------------------------------------
module tb_core_seq;
    localparam int          DW  = 16;
    localparam int          NR  = 5;
    localparam int          TW  = 3;
    localparam logic [15:0] RPC = 16'h0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    core_seq_if #(.DATA_W(DW)) bus ();

    logic [DW-1:0]    dec_instruction;
    logic [DW-1:0]    dec_pc;
    logic [NR*DW-1:0] dec_regs;
    logic [DW-1:0]    dec_res;
    logic [TW-1:0]    dec_res_target;
    logic             dec_res_from_ram;
    logic             dec_ram_access;
    logic             dec_ram_op;
    logic [DW-1:0]    dec_ram_addr;
    logic [DW-1:0]    dec_ram_wdata;
    logic [3:0]       dec_ram_mode;
    logic             dec_halt;
    logic             run;
    logic             halt_out;

    core_seq #(.DATA_W(DW), .NREGS(NR), .TGT_W(TW), .RESET_PC(RPC)) dut (
        .clk              (clk),
        .rst              (rst),
        .mem              (bus),
        .dec_instruction  (dec_instruction),
        .dec_pc           (dec_pc),
        .dec_regs         (dec_regs),
        .dec_res          (dec_res),
        .dec_res_target   (dec_res_target),
        .dec_res_from_ram (dec_res_from_ram),
        .dec_ram_access   (dec_ram_access),
        .dec_ram_op       (dec_ram_op),
        .dec_ram_addr     (dec_ram_addr),
        .dec_ram_wdata    (dec_ram_wdata),
        .dec_ram_mode     (dec_ram_mode),
        .dec_halt         (dec_halt),
        .run              (run),
        .halt_out         (halt_out)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fetch_cyc = 0;

    logic [15:0] m_pc;
    logic [15:0] m_regs [NR];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Architectural result of one instruction, from the merge rules.
    function automatic logic [15:0] model_res(input logic [15:0] res, input logic [15:0] rd,
                                              input logic from_ram, input logic [3:0] mode);
        int r  = int'(res);
        int d  = int'(rd);
        int sw;
        if (!from_ram) return res;
        if (mode[0]) begin
            r = mode[1] ? (r - d + 65536) % 65536 : (r + d) % 65536;
            return r[15:0];
        end
        sw = mode[1] ? ((d % 256) * 256 + d / 256) : d;
        if (mode[2]) r = (r % 256) + (sw / 256) * 256;
        if (mode[3]) r = (r / 256) * 256 + (sw % 256);
        return r[15:0];
    endfunction

    function automatic logic [NR*DW-1:0] model_vec();
        logic [NR*DW-1:0] v = '0;
        for (int i = 0; i < NR; i++) v[(NR-i)*DW-1 -: DW] = m_regs[i];
        return v;
    endfunction

    task automatic model_reset();
        m_pc = RPC;
        for (int i = 0; i < NR; i++) m_regs[i] = 16'h0;
    endtask

    // Wait (bounded) until the core requests memory; leaves us at a negedge.
    task automatic wait_req(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.mem_req && n < 40);
        check({tag, "_req_seen"}, 128'(bus.mem_req), 128'(1));
    endtask

    // Hold ack low for 'waits' cycles checking the request is stable, then ack.
    task automatic serve(input string tag, input int waits, input logic [15:0] addr,
                         input logic we, input logic [15:0] wdata, input logic [15:0] rd);
        check({tag, "_addr"}, 128'(bus.mem_addr), 128'(addr));
        check({tag, "_we"},   128'(bus.mem_we),   128'(we));
        if (we) check({tag, "_wdata"}, 128'(bus.mem_wdata), 128'(wdata));
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check({tag, "_wait_req"},  128'(bus.mem_req),  128'(1));
            check({tag, "_wait_addr"}, 128'(bus.mem_addr), 128'(addr));
            check({tag, "_wait_we"},   128'(bus.mem_we),   128'(we));
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rd;
        @(posedge clk);
        #1;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'($urandom);
    endtask

    task automatic set_dec(input logic [2:0] tgt, input logic [15:0] res, input logic from_ram,
                           input logic access, input logic op, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [3:0] mode, input logic halt);
        dec_res_target   = tgt;
        dec_res          = res;
        dec_res_from_ram = from_ram;
        dec_ram_access   = access;
        dec_ram_op       = op;
        dec_ram_addr     = addr;
        dec_ram_wdata    = wdata;
        dec_ram_mode     = mode;
        dec_halt         = halt;
    endtask

    // Fetch checks the architectural state left by the previous instruction.
    task automatic do_fetch(output logic [15:0] word, input int fw);
        word = 16'($urandom);
        wait_req("fetch");
        check("fetch_pc",   128'(bus.mem_addr), 128'(m_pc));
        check("dec_pc",     128'(dec_pc),       128'(m_pc));
        check("regs",       128'(dec_regs),     128'(model_vec()));
        check("halt_low",   128'(halt_out),     128'(0));
        serve("fetch", fw, m_pc, 1'b0, 16'h0, word);
        fetch_cyc = cyc;
        @(negedge clk);
        check("dec_instr", 128'(dec_instruction), 128'(word));
        @(posedge clk);
        #1;
    endtask

    task automatic exec_instr(input logic [2:0] tgt, input logic [15:0] res, input logic from_ram,
                              input logic access, input logic op, input logic [15:0] addr,
                              input logic [15:0] wdata, input logic [3:0] mode,
                              input int fw, input int mw, input logic [15:0] rd);
        logic [15:0] word;
        logic [15:0] eff;
        logic [15:0] r;
        set_dec(tgt, res, from_ram, access, op, addr, wdata, mode, 1'b0);
        do_fetch(word, fw);
        eff = 16'h0;
        if (access) begin
            wait_req("data");
            serve("data", mw, addr, op, wdata, rd);
            if (!op) eff = rd;
        end
        r = model_res(res, eff, from_ram, mode);
        if (tgt == 3'd1) begin
            m_pc = r;
        end else begin
            if (int'(tgt) >= 2 && int'(tgt) <= NR + 1) m_regs[int'(tgt) - 2] = r;
            m_pc = m_pc + 16'd1;
        end
    endtask

    initial begin
        int c_prev;
        logic [15:0] word;

        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0;
        run = 1'b0;
        set_dec(3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0);

        // Reset state.
        rst = 1'b1;
        #12;
        check("rst_req",   128'(bus.mem_req),   128'(0));
        check("rst_we",    128'(bus.mem_we),    128'(0));
        check("rst_addr",  128'(bus.mem_addr),  128'(0));
        check("rst_wdata", 128'(bus.mem_wdata), 128'(0));
        check("rst_halt",  128'(halt_out),      128'(0));
        check("rst_pc",    128'(dec_pc),        128'(RPC));
        check("rst_instr", 128'(dec_instruction), 128'(0));
        check("rst_regs",  128'(dec_regs),      128'(0));
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Zero wait, reg 0 <= 0x1234.
        exec_instr(3'd2, 16'h1234, 0, 0, 0, 16'h0, 16'h0, 4'h0, 0, 0, 16'h0);
        c_prev = fetch_cyc;
        // Read with 3 wait states, upper/lower replace, no swap -> 0xABCD.
        exec_instr(3'd3, 16'h0000, 1, 1, 0, 16'h0100, 16'h0, 4'b1100, 0, 3, 16'hABCD);
        check("thru_nonmem", 128'(fetch_cyc - c_prev), 128'(3));
        // Add and subtract merges.
        exec_instr(3'd4, 16'h0005, 1, 1, 0, 16'h0101, 16'h0, 4'b0001, 0, 0, 16'h0007);
        c_prev = fetch_cyc;
        exec_instr(3'd5, 16'h0005, 1, 1, 0, 16'h0102, 16'h0, 4'b0011, 0, 0, 16'h0007);
        check("thru_mem", 128'(fetch_cyc - c_prev), 128'(4));
        // Swapped halves, lower only.
        exec_instr(3'd6, 16'h1100, 1, 1, 0, 16'h0103, 16'h0, 4'b1010, 1, 1, 16'h3456);
        // Write with wait states, no target.
        exec_instr(3'd0, 16'h7777, 0, 1, 1, 16'h0200, 16'h5A5A, 4'h0, 0, 2, 16'hDEAD);
        // Out-of-range target: no register write.
        exec_instr(3'd7, 16'h9999, 0, 0, 0, 16'h0, 16'h0, 4'h0, 2, 0, 16'h0);
        // Jumps and PC wrap.
        exec_instr(3'd1, 16'h0040, 0, 0, 0, 16'h0, 16'h0, 4'h0, 0, 0, 16'h0);
        exec_instr(3'd1, 16'hFFFF, 0, 0, 0, 16'h0, 16'h0, 4'h0, 0, 0, 16'h0);
        exec_instr(3'd0, 16'h0000, 0, 0, 0, 16'h0, 16'h0, 4'h0, 0, 0, 16'h0);
        check("wrap_model_pc", 128'(m_pc), 128'(0));

        // HALT: sticky, no requests, stray acks ignored, run restarts at pc+1.
        set_dec(3'd2, 16'hBEEF, 0, 0, 0, 16'h0, 16'h0, 4'h0, 1'b1);
        do_fetch(word, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("halt_out", 128'(halt_out),    128'(1));
            check("halt_req", 128'(bus.mem_req), 128'(0));
            bus.mem_ack   = i[0];
            bus.mem_rdata = 16'($urandom);
        end
        bus.mem_ack = 1'b0;
        check("halt_pc", 128'(dec_pc), 128'(m_pc));
        check("halt_regs", 128'(dec_regs), 128'(model_vec()));
        dec_halt = 1'b0;
        @(negedge clk);
        run = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        m_pc = m_pc + 16'd1;

        // Randomised instructions; run toggles freely and must be ignored.
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  t;
            logic        acc, op, fr;
            t   = 3'($urandom_range(0, 7));
            acc = 1'($urandom);
            op  = acc ? 1'($urandom) : 1'b0;
            fr  = (acc && !op) ? 1'($urandom) : 1'b0;
            run = 1'($urandom);
            exec_instr(t, 16'($urandom), fr, acc, op, 16'($urandom), 16'($urandom),
                       4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 16'($urandom));
        end
        run = 1'b0;
        exec_instr(3'd2, 16'hC0DE, 0, 0, 0, 16'h0, 16'h0, 4'h0, 0, 0, 16'h0);

        // Reset during a write wait: request drops before the next edge.
        set_dec(3'd3, 16'h1111, 0, 1, 1, 16'h0300, 16'hA5A5, 4'h0, 1'b0);
        do_fetch(word, 0);
        wait_req("rstmem");
        check("rstmem_we", 128'(bus.mem_we), 128'(1));
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rstmem_req_drop", 128'(bus.mem_req), 128'(0));
        check("rstmem_we_drop",  128'(bus.mem_we),  128'(0));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("rstmem_regs", 128'(dec_regs), 128'(0));
        exec_instr(3'd4, 16'h0F0F, 0, 0, 0, 16'h0, 16'h0, 4'h0, 0, 0, 16'h0);
        exec_instr(3'd0, 16'h0000, 0, 0, 0, 16'h0, 16'h0, 4'h0, 0, 0, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
